// File: rtl/ddr_frame_reader_pkg.sv
// Shared types and constants for the DDR frame reader: FSM encoding and chunk size.
// The optional DDR_FRAME_READER_LOOP_EN build is handled in the top module.
package ddr_frame_reader_pkg;

  localparam int CHUNK_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/frame_reader_fifo.sv
// Single-clock synchronous FIFO holding read beats; the head is visible combinationally.
// Writes while full and reads while empty are discarded so occupancy never leaves 0..DEPTH.
module frame_reader_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 128
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr;
  logic             do_rd;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd) count_d = count_q + CW'(1);
    else if (!do_wr && do_rd) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; the top masks the head while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/ddr_frame_reader.sv
// Reads a frame of 16-byte chunks over AXI (single-beat bursts) and streams them out in order.
// Define DDR_FRAME_READER_LOOP_EN to replay the latched frame continuously until reset.
//
// Handshakes: a transfer happens on a rising edge where valid && ready; a raised
// valid (and its payload) holds until that transfer; ready may change freely.
module ddr_frame_reader
  import ddr_frame_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [CNT_WIDTH-1:0]  num_chunks_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out,
  output logic [1:0]            dbg_state_out,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = PW + 1;

  state_t                state_q, state_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  ar_cnt_q, ar_cnt_d;
  logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic [PW-1:0]         inflight_q, inflight_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
`ifdef DDR_FRAME_READER_LOOP_EN
  logic [ADDR_WIDTH-1:0] base_q, base_d;
`endif

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  pop;
  logic                  last_beat;
  logic [SW-1:0]         budget_next;

  frame_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i     (clk_in),
    .rst_n_i   (rst_n_in),
    .wr_en_i   (r_hs),
    .wr_data_i (m_axi_rdata),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // rready is held low during reset even though the reset FIFO is not full.
  assign m_axi_rready  = rst_n_in & ~fifo_full;
  assign r_hs          = m_axi_rvalid & m_axi_rready;
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_head;
  assign last_beat     = (state_q != IDLE) && (out_cnt_q == num_q - CNT_WIDTH'(1));
  assign m_axis_tlast  = m_axis_tvalid & last_beat;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign ar_hs         = arvalid_q & m_axi_arready;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign busy_out      = (state_q != IDLE);
  assign done_out      = done_q;
  assign err_out       = err_q;
  assign dbg_state_out = state_q;

  // Reads in flight plus FIFO occupancy after this edge; this sum bounds new ARs.
  assign budget_next = SW'(inflight_q) + SW'(fifo_count) + SW'(ar_hs) - SW'(pop);

  always_comb begin
    inflight_d = inflight_q;
    if (ar_hs && !r_hs) inflight_d = inflight_q + PW'(1);
    else if (!ar_hs && r_hs && inflight_q != '0) inflight_d = inflight_q - PW'(1);
  end

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    num_d     = num_q;
    ar_cnt_d  = ar_cnt_q;
    out_cnt_d = pop ? out_cnt_q + CNT_WIDTH'(1) : out_cnt_q;
    done_d    = 1'b0;
    err_d     = err_q | (r_hs & (m_axi_rresp != 2'b00));
`ifdef DDR_FRAME_READER_LOOP_EN
    base_d    = base_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_in) begin
          if (num_chunks_in != '0) begin
            state_d   = ISSUE;
            num_d     = num_chunks_in;
            araddr_d  = base_addr_in;
            ar_cnt_d  = '0;
            out_cnt_d = '0;
`ifdef DDR_FRAME_READER_LOOP_EN
            base_d    = base_addr_in;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (ar_hs) begin
          ar_cnt_d = ar_cnt_q + CNT_WIDTH'(1);
          araddr_d = araddr_q + ADDR_WIDTH'(CHUNK_BYTES);
        end
        if (ar_hs && (ar_cnt_q == num_q - CNT_WIDTH'(1))) begin
          state_d   = DRAIN;
          arvalid_d = 1'b0;
        end else if (!arvalid_q || ar_hs) begin
          arvalid_d = (budget_next < SW'(FIFO_DEPTH));
        end
      end
      DRAIN: begin
        if (pop && m_axis_tlast) begin
          done_d = 1'b1;
`ifdef DDR_FRAME_READER_LOOP_EN
          state_d   = ISSUE;
          araddr_d  = base_q;
          ar_cnt_d  = '0;
          out_cnt_d = '0;
`else
          state_d   = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      num_q      <= '0;
      ar_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef DDR_FRAME_READER_LOOP_EN
      base_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      num_q      <= num_d;
      ar_cnt_q   <= ar_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef DDR_FRAME_READER_LOOP_EN
      base_q     <= base_d;
`endif
    end
  end

endmodule

// File: tb/tb_ddr_frame_reader.sv
// Self-checking bench for ddr_frame_reader: table of frames plus hand-written corner sequences.
module tb_ddr_frame_reader;

  localparam int AW    = 27;
  localparam int DW    = 128;
  localparam int CW    = 20;
  localparam int DEPTH = 8;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          start_in;
  logic [AW-1:0] base_addr_in;
  logic [CW-1:0] num_chunks_in;
  logic          busy_out, done_out, err_out;
  logic [1:0]    dbg_state_out;
  logic          m_axi_arvalid, m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axis_tvalid, m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  always #5 clk_in = ~clk_in;

  ddr_frame_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .base_addr_in(base_addr_in), .num_chunks_in(num_chunks_in),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
    .dbg_state_out(dbg_state_out),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
  );

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    int            tr_mode;
    int            ar_mode;
    int            bad_idx;
    logic          exp_err;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t vecs [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tr_mode = 1;
  int ar_mode = 1;
  int bad_idx = -1;
  int done_cnt = 0;
  int stab_err = 0, budget_err = 0, lat_err = 0, busy_err = 0;
  int ar_total = 0, pop_total = 0;
  logic          ar_wait = 1'b0;
  logic [AW-1:0] ar_wait_addr = '0;
  logic          r_prev = 1'b0;

  logic [AW-1:0] ar_log [$];
  logic [AW-1:0] pend_addr [$];
  int            pend_due [$];
  int            pend_k [$];
  logic [DW-1:0] out_data [$];
  logic          out_last [$];
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {5'b0, a};
    return {w ^ 32'hDEAD_BEEF, w ^ 32'h1234_5678, ~w, w};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    ar_log.delete();
    out_data.delete();
    out_last.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [AW-1:0] base, input int n);
    @(negedge clk_in);
    start_in      = 1'b1;
    base_addr_in  = base;
    num_chunks_in = CW'(n);
    @(negedge clk_in);
    start_in      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk_in);
      if (done_cnt > 0) seen = 1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    repeat (5) @(negedge clk_in);
  endtask

  task automatic check_frame(input string tag, input logic [AW-1:0] base, input int n,
                             input logic exp_err, input logic [AW-1:0] exp_first,
                             input logic [AW-1:0] exp_last);
    int bad_addr, bad_data, bad_last;
    logic [AW-1:0] a;
    bad_addr = 0; bad_data = 0; bad_last = 0;
    exp_q.delete();
    chk({tag, "_ar_count"}, ar_log.size(), n);
    if (ar_log.size() > 0) begin
      chk({tag, "_first_addr"}, ar_log[0], exp_first);
      chk({tag, "_last_addr"}, ar_log[ar_log.size()-1], exp_last);
    end
    for (int k = 0; k < n; k++) begin
      a = base + AW'(16 * k);
      exp_q.push_back(mk_data(a));
      if (k < ar_log.size() && ar_log[k] !== a) bad_addr++;
    end
    chk({tag, "_addr_seq"}, bad_addr, 0);
    chk({tag, "_beat_count"}, out_data.size(), n);
    for (int k = 0; k < out_data.size() && exp_q.size() > 0; k++) begin
      if (out_data[k] !== exp_q.pop_front()) bad_data++;
      if (out_last[k] !== (k == n - 1)) bad_last++;
    end
    chk({tag, "_data_seq"}, bad_data, 0);
    chk({tag, "_tlast_pos"}, bad_last, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_after"}, busy_out, 0);
    chk({tag, "_err"}, err_out, exp_err);
  endtask

  // AXI slave, stream sink and protocol monitor; everything runs on the falling edge.
  initial begin
    forever begin
      @(negedge clk_in);
      cyc++;
      if (!rst_n_in) begin
        pend_addr.delete(); pend_due.delete(); pend_k.delete();
        m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        m_axi_arready = 1'b0; m_axis_tready = 1'b0;
        ar_total = 0; pop_total = 0; ar_wait = 1'b0; r_prev = 1'b0;
      end else begin
        if (ar_wait && (m_axi_arvalid !== 1'b1 || m_axi_araddr !== ar_wait_addr)) stab_err++;
        if (m_axi_arvalid && (ar_total - pop_total) >= DEPTH) budget_err++;
        if (r_prev && !m_axis_tvalid) lat_err++;
        if (done_out) begin
          done_cnt++;
          if (busy_out) busy_err++;
        end
        m_axi_arready = (ar_mode == 2) ? 1'($urandom_range(0, 1)) : (ar_mode != 0);
        m_axis_tready = (tr_mode == 2) ? 1'($urandom_range(0, 1)) : (tr_mode != 0);
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = mk_data(pend_addr[0]);
          m_axi_rresp  = (pend_k[0] == bad_idx) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rdata  = '0;
          m_axi_rresp  = 2'b00;
        end
        ar_wait      = m_axi_arvalid && !m_axi_arready;
        ar_wait_addr = m_axi_araddr;
        if (m_axi_arvalid && m_axi_arready) begin
          pend_k.push_back(ar_log.size());
          ar_log.push_back(m_axi_araddr);
          pend_addr.push_back(m_axi_araddr);
          pend_due.push_back(cyc + 2);
          ar_total++;
        end
        r_prev = m_axi_rvalid && m_axi_rready;
        if (r_prev) begin
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
          void'(pend_k.pop_front());
        end
        if (m_axis_tvalid && m_axis_tready) begin
          out_data.push_back(m_axis_tdata);
          out_last.push_back(m_axis_tlast);
          pop_total++;
        end
      end
    end
  end

  initial begin
    int reached;
    vecs[0] = '{base: 27'h0000100, n: 4,  tr_mode: 1, ar_mode: 1, bad_idx: -1, exp_err: 1'b0,
                exp_first: 27'h0000100, exp_last: 27'h0000130};
    vecs[1] = '{base: 27'h7FFFFF0, n: 2,  tr_mode: 1, ar_mode: 1, bad_idx: -1, exp_err: 1'b0,
                exp_first: 27'h7FFFFF0, exp_last: 27'h0000000};
    vecs[2] = '{base: 27'h0000200, n: 3,  tr_mode: 1, ar_mode: 1, bad_idx: 1,  exp_err: 1'b1,
                exp_first: 27'h0000200, exp_last: 27'h0000220};
    vecs[3] = '{base: 27'h0001000, n: 10, tr_mode: 2, ar_mode: 2, bad_idx: -1, exp_err: 1'b1,
                exp_first: 27'h0001000, exp_last: 27'h0001090};

    rst_n_in = 1'b0; start_in = 1'b0; base_addr_in = '0; num_chunks_in = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Zero-length frame: done pulse only.
    clear_logs();
    do_start(27'h0000500, 0);
    chk("zero_done", done_out, 1);
    chk("zero_busy", busy_out, 0);
    repeat (8) @(negedge clk_in);
    chk("zero_no_ar", ar_log.size(), 0);

    // Second start while busy is ignored.
    clear_logs();
    do_start(27'h0000300, 3);
    chk("start_busy", busy_out, 1);
    @(negedge clk_in);
    start_in = 1'b1; base_addr_in = 27'h0000900; num_chunks_in = CW'(5);
    @(negedge clk_in);
    start_in = 1'b0;
    wait_done("ign", 500);
    check_frame("ign", 27'h0000300, 3, 1'b0, 27'h0000300, 27'h0000320);

    // Output stalled: issue stops at FIFO_DEPTH, resumes on tready.
    clear_logs();
    tr_mode = 0;
    do_start(27'h0000000, 12);
    repeat (60) @(negedge clk_in);
    chk("bp_ar_cap", ar_log.size(), 8);
    chk("bp_arvalid_low", m_axi_arvalid, 0);
    chk("bp_no_beats", out_data.size(), 0);
    tr_mode = 1;
    wait_done("bp", 1000);
    check_frame("bp", 27'h0000000, 12, 1'b0, 27'h0000000, 27'h00000B0);

    // Reset while draining.
    clear_logs();
    tr_mode = 0;
    do_start(27'h0000400, 6);
    reached = 0;
    for (int i = 0; i < 200 && reached == 0; i++) begin
      @(negedge clk_in);
      if (ar_log.size() == 6) reached = 1;
    end
    chk("mid_all_ar", reached, 1);
    @(posedge clk_in);
    #1;
    chk("mid_state_drain", dbg_state_out, 2'd2);
    #1 rst_n_in = 1'b0;
    #1;
    chk("mid_rst_flags", {busy_out, done_out, err_out, m_axi_arvalid, m_axi_rready,
                          m_axis_tvalid, m_axis_tlast}, 7'b0);
    chk("mid_rst_araddr", m_axi_araddr, 0);
    chk("mid_rst_tdata", m_axis_tdata, 0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    tr_mode = 1;
    repeat (3) @(negedge clk_in);
    chk("mid_no_done", done_cnt, 0);
    chk("mid_busy_clear", busy_out, 0);

    for (int i = 0; i < 4; i++) begin
      clear_logs();
      tr_mode = vecs[i].tr_mode;
      ar_mode = vecs[i].ar_mode;
      bad_idx = vecs[i].bad_idx;
      do_start(vecs[i].base, vecs[i].n);
      wait_done($sformatf("vec%0d", i), 2000);
      check_frame($sformatf("vec%0d", i), vecs[i].base, vecs[i].n, vecs[i].exp_err,
                  vecs[i].exp_first, vecs[i].exp_last);
    end

    chk("ar_stable", stab_err, 0);
    chk("ar_budget", budget_err, 0);
    chk("r_to_tvalid", lat_err, 0);
    chk("done_with_busy", busy_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
